// File: rtl/chip_74163_test_ctrl.sv
// Chip-checker sequencer for a 74163 4-bit synchronous counter: drives a fixed
// 23-step vector sequence, clocks the part on Pin2 and checks Q/RCO each step.
module chip_74163_test_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  output logic       Pin1,
  output logic       Pin2,
  output logic       Pin3,
  output logic       Pin4,
  output logic       Pin5,
  output logic       Pin6,
  output logic       Pin7,
  output logic       Pin9,
  output logic       Pin10,
  input  logic       Pin11,
  input  logic       Pin12,
  input  logic       Pin13,
  input  logic       Pin14,
  input  logic       Pin15,
  output logic       Done,
  output logic       RSLT,
  input  logic       DISP_RSLT,
  output logic [4:0] FailStep
);

  localparam int unsigned CW        = $clog2(SETTLE_CYCLES);
  localparam logic [4:0]  LAST_STEP = 5'd22;
  localparam logic [4:0]  NO_FAIL   = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CLK_HI, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  // Control vector {CLR_n, LOAD_n, ENP, ENT, D[3:0]} for a step.
  function automatic logic [7:0] step_ctrl(input logic [4:0] s);
    case (s)
      5'd0:    step_ctrl = {4'b0111, 4'h0};
      5'd17:   step_ctrl = {4'b1011, 4'hA};
      5'd18:   step_ctrl = {4'b1101, 4'h0};
      5'd19:   step_ctrl = {4'b1110, 4'h0};
      5'd20:   step_ctrl = {4'b1001, 4'hF};
      5'd21:   step_ctrl = {4'b1110, 4'h0};
      5'd22:   step_ctrl = {4'b0011, 4'h5};
      default: step_ctrl = {4'b1111, 4'h0};
    endcase
  endfunction

  // Expected {Q[3:0], RCO} after the step's clock pulse.
  function automatic logic [4:0] step_exp(input logic [4:0] s);
    case (s)
      5'd17, 5'd18, 5'd19: step_exp = {4'hA, 1'b0};
      5'd20:               step_exp = {4'hF, 1'b1};
      5'd21:               step_exp = {4'hF, 1'b0};
      5'd22:               step_exp = {4'h0, 1'b0};
      default:             step_exp = {s[3:0], (s == 5'd15)};
    endcase
  endfunction

  state_t        state_q;
  logic [4:0]    step_q;
  logic [CW-1:0] cnt_q;
  logic          pass_q;
  logic [4:0]    sync1_q, sync2_q;

  logic [7:0]    nxt_ctrl;
  logic [4:0]    cur_exp;
  logic          last_cnt;
  logic          load_vec;
  logic          go_done;

  always_comb begin
    nxt_ctrl = step_ctrl((state_q == S_CHECK) ? step_q + 5'd1 : 5'd0);
    cur_exp  = step_exp(step_q);
    last_cnt = (cnt_q == CW'(SETTLE_CYCLES - 1));
    go_done  = (state_q == S_CHECK) && (step_q == LAST_STEP);
    load_vec = ((state_q == S_IDLE) && Run) ||
               ((state_q == S_CHECK) && (step_q != LAST_STEP));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      FailStep <= NO_FAIL;
      Done     <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      {Pin1, Pin9, Pin7, Pin10} <= 4'b1100;
      {Pin6, Pin5, Pin4, Pin3}  <= 4'h0;
      Pin2     <= 1'b0;
    end else begin
      sync1_q <= {Pin11, Pin12, Pin13, Pin14, Pin15};
      sync2_q <= sync1_q;

      case (state_q)
        S_IDLE: if (Run) begin
          state_q  <= S_SETUP;
          step_q   <= '0;
          cnt_q    <= '0;
          pass_q   <= 1'b1;
          FailStep <= NO_FAIL;
        end
        S_SETUP: if (last_cnt) begin
          cnt_q   <= '0;
          state_q <= S_CLK_HI;
          Pin2    <= 1'b1;
        end else cnt_q <= cnt_q + CW'(1);
        S_CLK_HI: if (last_cnt) begin
          cnt_q   <= '0;
          state_q <= S_SETTLE;
          Pin2    <= 1'b0;
        end else cnt_q <= cnt_q + CW'(1);
        S_SETTLE: if (last_cnt) begin
          cnt_q   <= '0;
          state_q <= S_CHECK;
        end else cnt_q <= cnt_q + CW'(1);
        S_CHECK: begin
          if (sync2_q != cur_exp) begin
            pass_q <= 1'b0;
            if (FailStep == NO_FAIL) FailStep <= step_q;
          end
          if (step_q == LAST_STEP) begin
            state_q <= S_DONE;
            Done    <= 1'b1;
          end else begin
            step_q  <= step_q + 5'd1;
            state_q <= S_SETUP;
          end
        end
        S_DONE: if (!Run) begin
          state_q <= S_IDLE;
          Done    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      // Data/control pins only move on SETUP entry or when the run completes.
      if (load_vec) begin
        {Pin1, Pin9, Pin7, Pin10} <= nxt_ctrl[7:4];
        {Pin6, Pin5, Pin4, Pin3}  <= nxt_ctrl[3:0];
      end else if (go_done) begin
        {Pin1, Pin9, Pin7, Pin10} <= 4'b1100;
        {Pin6, Pin5, Pin4, Pin3}  <= 4'h0;
      end
    end
  end

  assign RSLT = DISP_RSLT & Done & pass_q;

endmodule

// File: tb/tb_chip_74163_test_ctrl.sv
// Directed bench for chip_74163_test_ctrl with a behavioural 74163 socket model
// that can be switched into two faulty variants.
module tb_chip_74163_test_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic DISP_RSLT = 1'b1;
  logic Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10;
  logic Pin11, Pin12, Pin13, Pin14, Pin15;
  logic Done, RSLT;
  logic [4:0] FailStep;

  int n_checks = 0;
  int n_fail   = 0;
  int fault    = 0;   // 0 good, 1 RCO stuck at 0, 2 clear ignored while loading
  logic [3:0] mq = 4'h0;

  always #5 Clk = ~Clk;

  chip_74163_test_ctrl #(.SETTLE_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run),
    .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5), .Pin6(Pin6),
    .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10),
    .Pin11(Pin11), .Pin12(Pin12), .Pin13(Pin13), .Pin14(Pin14), .Pin15(Pin15),
    .Done(Done), .RSLT(RSLT), .DISP_RSLT(DISP_RSLT), .FailStep(FailStep)
  );

  always @(posedge Pin2) begin
    if (!Pin1 && !(fault == 2 && !Pin9)) mq <= 4'h0;
    else if (!Pin9)                      mq <= {Pin6, Pin5, Pin4, Pin3};
    else if (Pin7 && Pin10)              mq <= mq + 4'h1;
  end
  assign Pin14 = mq[0];
  assign Pin13 = mq[1];
  assign Pin12 = mq[2];
  assign Pin11 = mq[3];
  assign Pin15 = (fault == 1) ? 1'b0 : (Pin10 && mq == 4'hF);

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; DISP_RSLT = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({Done, RSLT} !== 2'b00) begin
      n_fail++; $display("FAIL reset_done_rslt: got %b want 00", {Done, RSLT});
    end
    n_checks++;
    if (FailStep !== 5'd31) begin
      n_fail++; $display("FAIL reset_failstep: got %0d want 31", FailStep);
    end
    n_checks++;
    if ({Pin2, Pin1, Pin9, Pin7, Pin10, Pin6, Pin5, Pin4, Pin3} !== 9'b0_1100_0000) begin
      n_fail++;
      $display("FAIL reset_pins: got %b want 011000000",
               {Pin2, Pin1, Pin9, Pin7, Pin10, Pin6, Pin5, Pin4, Pin3});
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_good_run(input string tag);
    fault = 0; DISP_RSLT = 1'b1; Run = 1'b1;
    tick();                         // edge k samples Run
    Run = 1'b0;
    n_checks++;
    if ({Pin2, Pin1, Pin9, Pin7, Pin10} !== 5'b00111) begin
      n_fail++;
      $display("FAIL %s_step0_pins: got %b want 00111", tag, {Pin2, Pin1, Pin9, Pin7, Pin10});
    end
    repeat (2) tick();              // edge k+2: CLK_HI
    n_checks++;
    if (Pin2 !== 1'b1) begin
      n_fail++; $display("FAIL %s_clk_hi: Pin2 got %b want 1", tag, Pin2);
    end
    repeat (158) tick();            // edge k+160
    n_checks++;
    if (Done !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_early: got %b want 0", tag, Done);
    end
    tick();                         // edge k+161
    n_checks++;
    if ({Done, RSLT} !== 2'b11) begin
      n_fail++; $display("FAIL %s_done_rslt: got %b want 11", tag, {Done, RSLT});
    end
    n_checks++;
    if (FailStep !== 5'd31) begin
      n_fail++; $display("FAIL %s_failstep: got %0d want 31", tag, FailStep);
    end
    tick();
    n_checks++;
    if ({Done, RSLT} !== 2'b00) begin
      n_fail++; $display("FAIL %s_back_to_idle: got %b want 00", tag, {Done, RSLT});
    end
  endtask

  task automatic test_fault(input int f, input logic [4:0] exp_fs, input string tag);
    int cycles;
    fault = f; DISP_RSLT = 1'b1; Run = 1'b1;
    tick();
    cycles = 0;
    while (Done !== 1'b1 && cycles < 200) begin
      tick(); cycles++;
    end
    n_checks++;
    if (Done !== 1'b1 || cycles != 161) begin
      n_fail++; $display("FAIL %s_latency: got %0d cycles want 161", tag, cycles);
    end
    n_checks++;
    if (RSLT !== 1'b0) begin
      n_fail++; $display("FAIL %s_rslt: got %b want 0", tag, RSLT);
    end
    n_checks++;
    if (FailStep !== exp_fs) begin
      n_fail++; $display("FAIL %s_failstep: got %0d want %0d", tag, FailStep, exp_fs);
    end
    Run = 1'b0;
    tick();
    fault = 0;
  endtask

  task automatic test_disp_rslt_run_held();
    int cycles;
    fault = 0; DISP_RSLT = 1'b0; Run = 1'b1;
    tick();
    cycles = 0;
    while (Done !== 1'b1 && cycles < 200) begin
      tick(); cycles++;
    end
    n_checks++;
    if ({Done, RSLT} !== 2'b10) begin
      n_fail++; $display("FAIL disp_off: Done,RSLT got %b want 10", {Done, RSLT});
    end
    DISP_RSLT = 1'b1;
    #1;
    n_checks++;
    if ({Done, RSLT} !== 2'b11) begin
      n_fail++; $display("FAIL disp_on: Done,RSLT got %b want 11", {Done, RSLT});
    end
    repeat (10) tick();             // Run still high: must sit in DONE
    n_checks++;
    if ({Done, RSLT, Pin1, Pin7, Pin10, Pin2} !== 6'b111000) begin
      n_fail++;
      $display("FAIL run_held: Done,RSLT,Pin1,Pin7,Pin10,Pin2 got %b want 111000",
               {Done, RSLT, Pin1, Pin7, Pin10, Pin2});
    end
    n_checks++;
    if (FailStep !== 5'd31) begin
      n_fail++; $display("FAIL run_held_failstep: got %0d want 31", FailStep);
    end
    Run = 1'b0;
    tick();
    n_checks++;
    if ({Done, RSLT} !== 2'b00) begin
      n_fail++; $display("FAIL run_release: got %b want 00", {Done, RSLT});
    end
    repeat (3) tick();
    n_checks++;
    if ({Done, Pin1, Pin7, Pin2} !== 4'b0100) begin
      n_fail++; $display("FAIL no_restart: got %b want 0100", {Done, Pin1, Pin7, Pin2});
    end
  endtask

  task automatic test_reset_mid();
    fault = 0; DISP_RSLT = 1'b1; Run = 1'b1;
    tick();
    Run = 1'b0;
    repeat (65) tick();             // step 9, CLK_HI
    n_checks++;
    if (Pin2 !== 1'b1) begin
      n_fail++; $display("FAIL mid_clk_hi: Pin2 got %b want 1", Pin2);
    end
    Reset = 1'b1;
    tick();
    n_checks++;
    if ({Done, RSLT, Pin2, Pin1, Pin9, Pin7, Pin10, Pin6, Pin5, Pin4, Pin3} !== 11'b00_0_1100_0000) begin
      n_fail++;
      $display("FAIL mid_reset_pins: got %b want 00011000000",
               {Done, RSLT, Pin2, Pin1, Pin9, Pin7, Pin10, Pin6, Pin5, Pin4, Pin3});
    end
    n_checks++;
    if (FailStep !== 5'd31) begin
      n_fail++; $display("FAIL mid_reset_failstep: got %0d want 31", FailStep);
    end
    Reset = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({Done, Pin2} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_idle: got %b want 00", {Done, Pin2});
    end
    test_good_run("after_reset");
  endtask

  initial begin
    test_reset();
    test_good_run("good");
    test_fault(1, 5'd15, "rco_stuck");
    test_fault(2, 5'd22, "clr_vs_load");
    test_disp_rslt_run_held();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
